// File: rtl/csr_ctrl.sv
// Execute-stage CSR requester: CSR read-modify-write, trap entry and MRET sequencing with PC redirect.
// CSR op responds 2 cycles after accept; req_ready is low in every state but IDLE, so new requests stall.
module csr_ctrl #(
    parameter int XLEN     = 32,
    parameter bit RO_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_rs1_idx,
    input  logic            req_exc,
    input  logic [3:0]      req_ecause,
    input  logic [XLEN-1:0] req_epc,
    input  logic [XLEN-1:0] req_etval,
    input  logic            req_mret,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            retire,
    output logic            crden,
    output logic [11:0]     craddr,
    input  logic [XLEN-1:0] crdata,
    output logic            cwren,
    output logic [11:0]     cwaddr,
    output logic [XLEN-1:0] cwdata,
    output logic            cexception,
    output logic [XLEN-1:0] cepc,
    output logic [3:0]      cecause,
    output logic [XLEN-1:0] cetval,
    output logic            cmret,
    input  logic            cexc_done,
    input  logic            cmret_done,
    input  logic [XLEN-1:0] cmtvec,
    input  logic [XLEN-1:0] cmepc
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_TRAP, S_TWAIT, S_MRET, S_MWAIT, S_REDIR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [4:0]        idx_q, idx_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_illegal_q, resp_illegal_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              retire_q, retire_d;
    logic              crden_q, crden_d;
    logic [11:0]       craddr_q, craddr_d;
    logic              cwren_q, cwren_d;
    logic [11:0]       cwaddr_q, cwaddr_d;
    logic [XLEN-1:0]   cwdata_q, cwdata_d;
    logic              cexception_q, cexception_d;
    logic [XLEN-1:0]   cepc_q, cepc_d;
    logic [3:0]        cecause_q, cecause_d;
    logic [XLEN-1:0]   cetval_q, cetval_d;
    logic              cmret_q, cmret_d;

    logic [XLEN-1:0]   src;
    logic [XLEN-1:0]   new_val;
    logic              wr_req;
    logic              illegal;

    // Read-modify-write datapath, evaluated while the read is on the bus in RD.
    always_comb begin
        src = op_q[2] ? {{(XLEN-5){1'b0}}, idx_q} : rs1_q;
        case (op_q[1:0])
            2'b10:   new_val = crdata | src;
            2'b11:   new_val = crdata & ~src;
            default: new_val = src;
        endcase
        wr_req  = (op_q[1:0] == 2'b01) || (idx_q != 5'd0);
        illegal = (RO_CHECK && wr_req && (addr_q[11:10] == 2'b11)) || (op_q[1:0] == 2'b00);
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        addr_d           = addr_q;
        rs1_d            = rs1_q;
        idx_d            = idx_q;
        req_ready_d      = 1'b0;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = '0;
        resp_illegal_d   = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        retire_d         = 1'b0;
        crden_d          = 1'b0;
        craddr_d         = '0;
        cwren_d          = 1'b0;
        cwaddr_d         = '0;
        cwdata_d         = '0;
        cexception_d     = 1'b0;
        cepc_d           = '0;
        cecause_d        = '0;
        cetval_d         = '0;
        cmret_d          = 1'b0;

        // Outputs are registered, so each branch drives what the next state presents.
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    rs1_d  = req_rs1;
                    idx_d  = req_rs1_idx;
                    if (req_exc) begin
                        state_d      = S_TRAP;
                        cexception_d = 1'b1;
                        cepc_d       = req_epc;
                        cecause_d    = req_ecause;
                        cetval_d     = req_etval;
                    end else if (req_mret) begin
                        state_d = S_MRET;
                        cmret_d = 1'b1;
                    end else begin
                        state_d  = S_RD;
                        crden_d  = 1'b1;
                        craddr_d = req_addr;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_RD: begin
                state_d        = S_WR;
                cwren_d        = wr_req && !illegal;
                cwaddr_d       = addr_q;
                cwdata_d       = new_val;
                resp_valid_d   = 1'b1;
                resp_rdata_d   = crdata;
                resp_illegal_d = illegal;
                retire_d       = !illegal;
            end
            S_TRAP:  state_d = S_TWAIT;
            S_TWAIT: begin
                if (cexc_done) begin
                    state_d          = S_REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = cmtvec;
                end
            end
            S_MRET:  state_d = S_MWAIT;
            S_MWAIT: begin
                if (cmret_done) begin
                    state_d          = S_REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = cmepc;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            rs1_q            <= '0;
            idx_q            <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_illegal_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            retire_q         <= 1'b0;
            crden_q          <= 1'b0;
            craddr_q         <= '0;
            cwren_q          <= 1'b0;
            cwaddr_q         <= '0;
            cwdata_q         <= '0;
            cexception_q     <= 1'b0;
            cepc_q           <= '0;
            cecause_q        <= '0;
            cetval_q         <= '0;
            cmret_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            addr_q           <= addr_d;
            rs1_q            <= rs1_d;
            idx_q            <= idx_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_illegal_q   <= resp_illegal_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            retire_q         <= retire_d;
            crden_q          <= crden_d;
            craddr_q         <= craddr_d;
            cwren_q          <= cwren_d;
            cwaddr_q         <= cwaddr_d;
            cwdata_q         <= cwdata_d;
            cexception_q     <= cexception_d;
            cepc_q           <= cepc_d;
            cecause_q        <= cecause_d;
            cetval_q         <= cetval_d;
            cmret_q          <= cmret_d;
        end
    end

    // MRET retires in the very cycle the CSR file acknowledges it, ahead of the redirect.
    assign retire         = retire_q || ((state_q == S_MWAIT) && cmret_done);
    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_illegal   = resp_illegal_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign crden          = crden_q;
    assign craddr         = craddr_q;
    assign cwren          = cwren_q;
    assign cwaddr         = cwaddr_q;
    assign cwdata         = cwdata_q;
    assign cexception     = cexception_q;
    assign cepc           = cepc_q;
    assign cecause        = cecause_q;
    assign cetval         = cetval_q;
    assign cmret          = cmret_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl: CSR ops against a fixed CSR table, trap, MRET and reset mid-trap.
module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_rs1;
    logic [4:0]  req_rs1_idx;
    logic        req_exc;
    logic [3:0]  req_ecause;
    logic [31:0] req_epc, req_etval;
    logic        req_mret;
    logic        resp_valid, resp_illegal;
    logic [31:0] resp_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        retire, crden, cwren, cexception, cmret;
    logic [11:0] craddr, cwaddr;
    logic [31:0] crdata, cwdata, cepc, cetval;
    logic [3:0]  cecause;
    logic        cexc_done, cmret_done;
    logic [31:0] cmtvec, cmepc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_ctrl #(.XLEN(32), .RO_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_rs1(req_rs1), .req_rs1_idx(req_rs1_idx),
        .req_exc(req_exc), .req_ecause(req_ecause), .req_epc(req_epc),
        .req_etval(req_etval), .req_mret(req_mret),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .retire(retire),
        .crden(crden), .craddr(craddr), .crdata(crdata),
        .cwren(cwren), .cwaddr(cwaddr), .cwdata(cwdata),
        .cexception(cexception), .cepc(cepc), .cecause(cecause), .cetval(cetval),
        .cmret(cmret), .cexc_done(cexc_done), .cmret_done(cmret_done),
        .cmtvec(cmtvec), .cmepc(cmepc)
    );

    // Static CSR file contents; unimplemented addresses read as zero.
    function automatic logic [31:0] csr_model(input logic [11:0] a);
        case (a)
            12'h340: return 32'h1234_5678;
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'hC00: return 32'h0000_1000;
            default: return 32'h0;
        endcase
    endfunction

    assign crdata = csr_model(craddr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_op = 0; req_addr = 0; req_rs1 = 0; req_rs1_idx = 0;
        req_exc = 0; req_ecause = 0; req_epc = 0; req_etval = 0; req_mret = 0;
    endtask

    // Issue one CSR op and check the RD and WR cycles against hand-computed values.
    task automatic csr_op(input string tag, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] idx,
                          input logic [31:0] e_rdata, input logic e_wren,
                          input logic [31:0] e_wdata, input logic e_ill, input logic e_ret);
        req_valid = 1; req_op = op; req_addr = addr; req_rs1 = rs1; req_rs1_idx = idx;
        tick();
        chk({tag, ".rd_crden"}, crden, 1);
        chk({tag, ".rd_craddr"}, craddr, addr);
        chk({tag, ".rd_ready"}, req_ready, 0);
        chk({tag, ".rd_resp"}, resp_valid, 0);
        idle_inputs();
        tick();
        chk({tag, ".resp_valid"}, resp_valid, 1);
        chk({tag, ".rdata"}, resp_rdata, e_rdata);
        chk({tag, ".cwren"}, cwren, e_wren);
        chk({tag, ".cwaddr"}, cwaddr, addr);
        chk({tag, ".cwdata"}, cwdata, e_wdata);
        chk({tag, ".illegal"}, resp_illegal, e_ill);
        chk({tag, ".retire"}, retire, e_ret);
        chk({tag, ".wr_crden"}, crden, 0);
        tick();
        chk({tag, ".idle_ready"}, req_ready, 1);
        chk({tag, ".idle_resp"}, resp_valid, 0);
        chk({tag, ".idle_cwren"}, cwren, 0);
    endtask

    initial begin
        rst = 0; idle_inputs();
        cexc_done = 0; cmret_done = 0; cmtvec = 32'h200; cmepc = 32'h104;
        @(negedge clk);
        tick();
        chk("rst.ready", req_ready, 1);
        chk("rst.resp", resp_valid, 0);
        chk("rst.redir", redirect_valid, 0);
        chk("rst.crden", crden, 0);
        chk("rst.cwren", cwren, 0);
        chk("rst.retire", retire, 0);
        chk("rst.cexc", cexception, 0);
        chk("rst.cmret", cmret, 0);
        rst = 1;
        tick();

        csr_op("rw_mscratch", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd1,
               32'h1234_5678, 1, 32'hDEAD_BEEF, 0, 1);
        csr_op("rs_mstatus_x0", 3'b010, 12'h300, 32'h0, 5'd0,
               32'h0000_0088, 0, 32'h0000_0088, 0, 1);
        csr_op("rci_mie", 3'b111, 12'h304, 32'hFFFF_FFFF, 5'd8,
               32'h0000_0888, 1, 32'h0000_0880, 0, 1);
        csr_op("rsi_mscratch", 3'b110, 12'h340, 32'h0, 5'h11,
               32'h1234_5678, 1, 32'h1234_5679, 0, 1);
        csr_op("rw_cycle_ro", 3'b001, 12'hC00, 32'h5, 5'd3,
               32'h0000_1000, 0, 32'h0000_0005, 1, 0);
        csr_op("rs_cycle_read", 3'b010, 12'hC00, 32'h0, 5'd0,
               32'h0000_1000, 0, 32'h0000_1000, 0, 1);
        csr_op("rw_unimpl", 3'b001, 12'h7C0, 32'hAB, 5'd2,
               32'h0, 1, 32'hAB, 0, 1);

        // Exception with mret and a CSR op also flagged: exception wins.
        req_valid = 1; req_exc = 1; req_mret = 1; req_op = 3'b001; req_addr = 12'h340;
        req_ecause = 4'd2; req_epc = 32'h100; req_etval = 32'h13;
        tick();
        chk("trap.cexc", cexception, 1);
        chk("trap.cepc", cepc, 32'h100);
        chk("trap.cecause", cecause, 2);
        chk("trap.cetval", cetval, 32'h13);
        chk("trap.cmret", cmret, 0);
        chk("trap.crden", crden, 0);
        chk("trap.ready", req_ready, 0);
        idle_inputs();
        tick();
        chk("twait.cexc", cexception, 0);
        chk("twait.retire", retire, 0);
        cexc_done = 1;
        tick();
        cexc_done = 0;
        chk("tredir.valid", redirect_valid, 1);
        chk("tredir.pc", redirect_pc, 32'h200);
        chk("tredir.retire", retire, 0);
        tick();
        chk("trap_end.redir", redirect_valid, 0);
        chk("trap_end.ready", req_ready, 1);

        // MRET, with the acknowledge held off one extra cycle.
        req_valid = 1; req_mret = 1;
        tick();
        chk("mret.cmret", cmret, 1);
        chk("mret.cexc", cexception, 0);
        chk("mret.ready", req_ready, 0);
        idle_inputs();
        tick();
        chk("mwait.cmret", cmret, 0);
        chk("mwait.retire_early", retire, 0);
        tick();
        chk("mwait2.redir", redirect_valid, 0);
        cmret_done = 1;
        #1;
        chk("mwait.retire", retire, 1);
        chk("mwait.redir", redirect_valid, 0);
        @(negedge clk);
        cmret_done = 0;
        chk("mredir.valid", redirect_valid, 1);
        chk("mredir.pc", redirect_pc, 32'h104);
        chk("mredir.retire", retire, 0);
        tick();
        chk("mret_end.ready", req_ready, 1);

        // Reset in TWAIT with a CSR op held on the request port.
        req_valid = 1; req_exc = 1; req_ecause = 4'd5; req_epc = 32'h300; req_etval = 32'h0;
        tick();
        chk("rtrap.cexc", cexception, 1);
        req_exc = 0; req_op = 3'b001; req_addr = 12'h340; req_rs1 = 32'h55; req_rs1_idx = 5'd4;
        tick();
        rst = 0;
        tick();
        cexc_done = 1;
        chk("rtw.ready", req_ready, 1);
        chk("rtw.redir", redirect_valid, 0);
        chk("rtw.crden", crden, 0);
        tick();
        cexc_done = 0;
        chk("rtw2.redir", redirect_valid, 0);
        chk("rtw2.crden", crden, 0);
        chk("rtw2.ready", req_ready, 1);
        rst = 1;
        tick();
        chk("rtw.accept_crden", crden, 1);
        chk("rtw.accept_craddr", craddr, 12'h340);
        chk("rtw.accept_redir", redirect_valid, 0);
        idle_inputs();
        tick();
        chk("rtw.resp_valid", resp_valid, 1);
        chk("rtw.rdata", resp_rdata, 32'h1234_5678);
        chk("rtw.cwdata", cwdata, 32'h55);
        tick();
        chk("rtw.end_ready", req_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
